// File: rtl/raster_frame_sequencer.sv
// Per-frame controller: clears the framebuffer, feeds triangles to the rasterizer one at a time,
// and muxes clear/raster writes onto one framebuffer port. Optional watchdog: RASTER_WATCHDOG_EN.
module raster_frame_sequencer #(
    parameter int VERTEX_WIDTH   = 12,
    parameter int FB_ADDR_WIDTH  = 17,
    parameter int FB_WIDTH       = 320,
    parameter int FB_HEIGHT      = 240,
    parameter int COLOR_WIDTH    = 12,
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 131072
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            frame_start,
    input  logic [COLOR_WIDTH-1:0]          clear_color,
    input  logic                            tri_valid,
    output logic                            tri_ready,
    input  logic                            tri_last,
    input  logic signed [VERTEX_WIDTH-1:0]  tri_x0,
    input  logic signed [VERTEX_WIDTH-1:0]  tri_y0,
    input  logic signed [VERTEX_WIDTH-1:0]  tri_x1,
    input  logic signed [VERTEX_WIDTH-1:0]  tri_y1,
    input  logic signed [VERTEX_WIDTH-1:0]  tri_x2,
    input  logic signed [VERTEX_WIDTH-1:0]  tri_y2,
    input  logic [COLOR_WIDTH-1:0]          tri_color,
    output logic                            r_rst,
    output logic signed [VERTEX_WIDTH-1:0]  r_x0,
    output logic signed [VERTEX_WIDTH-1:0]  r_y0,
    output logic signed [VERTEX_WIDTH-1:0]  r_x1,
    output logic signed [VERTEX_WIDTH-1:0]  r_y1,
    output logic signed [VERTEX_WIDTH-1:0]  r_x2,
    output logic signed [VERTEX_WIDTH-1:0]  r_y2,
    input  logic [FB_ADDR_WIDTH-1:0]        r_fb_addr,
    input  logic                            r_fb_we,
    input  logic                            r_done,
    output logic [FB_ADDR_WIDTH-1:0]        fb_addr,
    output logic [COLOR_WIDTH-1:0]          fb_data,
    output logic                            fb_we,
    output logic                            busy,
    output logic                            frame_done,
    output logic [COUNT_WIDTH-1:0]          tri_count,
    output logic                            raster_timeout,
    output logic [2:0]                      state_dbg
);

    // Triangle handshake: a triangle transfers on a rising clk edge where tri_valid && tri_ready;
    // tri_ready is high only in WAIT_TRI and the offer may change freely outside that cycle.

    localparam int NPIX = FB_WIDTH * FB_HEIGHT;
    localparam logic [FB_ADDR_WIDTH-1:0] LAST_ADDR = FB_ADDR_WIDTH'(NPIX - 1);

    if (NPIX > 2 ** FB_ADDR_WIDTH || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("raster_frame_sequencer: invalid parameters");
    end

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CLEAR      = 3'd1,
        S_WAIT_TRI   = 3'd2,
        S_RASTER     = 3'd3,
        S_FRAME_DONE = 3'd4
    } state_t;

    state_t                   state, state_next;
    logic [FB_ADDR_WIDTH-1:0] clear_addr;
    logic [COLOR_WIDTH-1:0]   clear_color_q;
    logic [COLOR_WIDTH-1:0]   tri_color_q;
    logic                     tri_last_q;
    logic                     frame_accept;
    logic                     tri_accept;
    logic                     tri_finish;
    logic                     timeout_hit;

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        tri_ready    = 1'b0;
        r_rst        = 1'b1;
        fb_we        = 1'b0;
        fb_addr      = '0;
        fb_data      = '0;
        frame_done   = 1'b0;
        busy         = 1'b1;
        frame_accept = 1'b0;
        tri_accept   = 1'b0;
        tri_finish   = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (frame_start) begin
                    frame_accept = 1'b1;
                    state_next   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                fb_we   = 1'b1;
                fb_addr = clear_addr;
                fb_data = clear_color_q;
                if (clear_addr == LAST_ADDR) state_next = S_WAIT_TRI;
            end
            S_WAIT_TRI: begin
                tri_ready = 1'b1;
                if (tri_valid) begin
                    tri_accept = 1'b1;
                    state_next = S_RASTER;
                end
            end
            S_RASTER: begin
                r_rst   = 1'b0;
                fb_we   = r_fb_we;
                fb_addr = r_fb_addr;
                fb_data = tri_color_q;
                if (r_done || timeout_hit) begin
                    tri_finish = 1'b1;
                    state_next = tri_last_q ? S_FRAME_DONE : S_WAIT_TRI;
                end
            end
            S_FRAME_DONE: begin
                frame_done = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clear_addr    <= '0;
            clear_color_q <= '0;
            tri_color_q   <= '0;
            tri_last_q    <= 1'b0;
            tri_count     <= '0;
            r_x0          <= '0;
            r_y0          <= '0;
            r_x1          <= '0;
            r_y1          <= '0;
            r_x2          <= '0;
            r_y2          <= '0;
        end else begin
            if (frame_accept) begin
                clear_color_q <= clear_color;
                clear_addr    <= '0;
                tri_count     <= '0;
            end else if (state == S_CLEAR) begin
                clear_addr <= clear_addr + 1'b1;
            end
            if (tri_accept) begin
                r_x0        <= tri_x0;
                r_y0        <= tri_y0;
                r_x1        <= tri_x1;
                r_y1        <= tri_y1;
                r_x2        <= tri_x2;
                r_y2        <= tri_y2;
                tri_color_q <= tri_color;
                tri_last_q  <= tri_last;
            end
            if (tri_finish) tri_count <= tri_count + 1'b1;
        end
    end

`ifdef RASTER_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            timeout_flag;

    // wd_cnt holds (RASTER cycles so far - 1); the final permitted cycle is the timeout cycle.
    assign timeout_hit    = (state == S_RASTER) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign raster_timeout = timeout_flag;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (tri_accept)              wd_cnt <= '0;
            else if (state == S_RASTER)  wd_cnt <= wd_cnt + 1'b1;
            if (timeout_hit && !r_done)  timeout_flag <= 1'b1;
        end
    end
`else
    assign timeout_hit    = 1'b0;
    assign raster_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_raster_frame_sequencer.sv
// Directed bench for raster_frame_sequencer on an 8x4 framebuffer with a scripted rasterizer model.
module tb_raster_frame_sequencer;

    localparam int VW   = 12;
    localparam int AW   = 17;
    localparam int CW   = 12;
    localparam int NW   = 16;
    localparam int NPIX = 32;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 frame_start;
    logic [CW-1:0]        clear_color;
    logic                 tri_valid;
    logic                 tri_ready;
    logic                 tri_last;
    logic signed [VW-1:0] tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2;
    logic [CW-1:0]        tri_color;
    logic                 r_rst;
    logic signed [VW-1:0] r_x0, r_y0, r_x1, r_y1, r_x2, r_y2;
    logic [AW-1:0]        r_fb_addr;
    logic                 r_fb_we;
    logic                 r_done;
    logic [AW-1:0]        fb_addr;
    logic [CW-1:0]        fb_data;
    logic                 fb_we;
    logic                 busy;
    logic                 frame_done;
    logic [NW-1:0]        tri_count;
    logic                 raster_timeout;
    logic [2:0]           state_dbg;

    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_timeout = 1'b0;

    raster_frame_sequencer #(
        .VERTEX_WIDTH(VW), .FB_ADDR_WIDTH(AW), .FB_WIDTH(8), .FB_HEIGHT(4),
        .COLOR_WIDTH(CW), .COUNT_WIDTH(NW), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rstn(rstn), .frame_start(frame_start), .clear_color(clear_color),
        .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_last(tri_last),
        .tri_x0(tri_x0), .tri_y0(tri_y0), .tri_x1(tri_x1), .tri_y1(tri_y1),
        .tri_x2(tri_x2), .tri_y2(tri_y2), .tri_color(tri_color),
        .r_rst(r_rst), .r_x0(r_x0), .r_y0(r_y0), .r_x1(r_x1), .r_y1(r_y1),
        .r_x2(r_x2), .r_y2(r_y2), .r_fb_addr(r_fb_addr), .r_fb_we(r_fb_we), .r_done(r_done),
        .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .busy(busy),
        .frame_done(frame_done), .tri_count(tri_count), .raster_timeout(raster_timeout),
        .state_dbg(state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not finish within 2 ms");
        $fatal(1, "time limit");
    end

    // Starts a frame, checks every clear write, and ends one negedge after the clear (in WAIT_TRI).
    task automatic test_clear(input logic [CW-1:0] color, input logic poke);
        frame_start = 1'b1;
        clear_color = color;
        @(negedge clk); #1;
        frame_start = 1'b0;
        clear_color = ~color;
        for (int i = 0; i < NPIX; i++) begin
            n_cmp++;
            if ({fb_we, fb_addr, fb_data, tri_ready} !== {1'b1, AW'(i), color, 1'b0}) begin
                n_err++;
                $display("FAIL clear_write[%0d]: we=%b addr=%0d data=%h ready=%b, want 1 %0d %h 0",
                         i, fb_we, fb_addr, fb_data, tri_ready, i, color);
            end
            if (poke) frame_start = (i == 5);
            @(negedge clk); #1;
        end
        frame_start = 1'b0;
        n_cmp++;
        if ({tri_ready, fb_we, busy} !== 3'b101) begin
            n_err++;
            $display("FAIL clear_end: ready=%b we=%b busy=%b, want 1 0 1", tri_ready, fb_we, busy);
        end
    endtask

    // Offers one triangle, plays the rasterizer for ncyc cycles (r_done in the last), checks the result.
    task automatic do_tri(input logic [6*VW-1:0] v, input logic [CW-1:0] col, input logic last,
                          input int ncyc, input logic hold, input logic poke, input int exp_count);
        int k;
        logic exp_we;
        {tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2} = v;
        tri_color = col;
        tri_last  = last;
        tri_valid = 1'b1;
        k = 0;
        while (tri_ready !== 1'b1 && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        n_cmp++;
        if ({tri_ready, r_rst} !== 2'b11) begin
            n_err++;
            $display("FAIL tri_wait_ready: ready=%b r_rst=%b, want 1 1", tri_ready, r_rst);
        end
        @(posedge clk); #1;
        {tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2} = ~v;
        tri_color = ~col;
        tri_last  = ~last;
        if (!hold || last) tri_valid = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            exp_we    = (c % 2 == 0);
            r_fb_we   = exp_we;
            r_fb_addr = AW'(200 + c);
            r_done    = (c == ncyc - 1);
            if (poke) frame_start = (c == 3);
            #1;
            n_cmp++;
            if ({r_rst, tri_ready, fb_we, fb_addr, fb_data} !== {1'b0, 1'b0, exp_we, AW'(200 + c), col}) begin
                n_err++;
                $display("FAIL raster_mirror[%0d]: r_rst=%b ready=%b we=%b addr=%0d data=%h, want 0 0 %b %0d %h",
                         c, r_rst, tri_ready, fb_we, fb_addr, fb_data, exp_we, 200 + c, col);
            end
            if (c == 0) begin
                n_cmp++;
                if ({r_x0, r_y0, r_x1, r_y1, r_x2, r_y2} !== v) begin
                    n_err++;
                    $display("FAIL raster_vertices: got %h want %h", {r_x0, r_y0, r_x1, r_y1, r_x2, r_y2}, v);
                end
            end
        end
        @(negedge clk);
        r_done      = 1'b0;
        r_fb_we     = 1'b0;
        frame_start = 1'b0;
        #1;
        n_cmp++;
        if ({r_rst, tri_count, raster_timeout, frame_done, tri_ready, fb_we} !==
            {1'b1, NW'(exp_count), exp_timeout, last, ~last, 1'b0}) begin
            n_err++;
            $display("FAIL tri_complete: r_rst=%b count=%0d to=%b fd=%b ready=%b we=%b, want 1 %0d %b %b %b 0",
                     r_rst, tri_count, raster_timeout, frame_done, tri_ready, fb_we,
                     exp_count, exp_timeout, last, ~last);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        n_cmp++;
        if ({r_rst, tri_ready, fb_we, fb_addr, fb_data, frame_done, tri_count, raster_timeout, busy} !==
            {1'b1, 1'b0, 1'b0, AW'(0), CW'(0), 1'b0, NW'(0), 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: r_rst=%b ready=%b we=%b addr=%0d data=%h fd=%b count=%0d to=%b busy=%b, want reset values",
                     r_rst, tri_ready, fb_we, fb_addr, fb_data, frame_done, tri_count, raster_timeout, busy);
        end
        n_cmp++;
        if ({r_x0, r_y0, r_x1, r_y1, r_x2, r_y2} !== '0) begin
            n_err++;
            $display("FAIL reset_vertices: got %h want 0", {r_x0, r_y0, r_x1, r_y1, r_x2, r_y2});
        end
    endtask

    task automatic test_single_triangle();
        test_clear(12'hABC, 1'b1);
        do_tri({12'd1, 12'd2, 12'd30, 12'd4, 12'd5, 12'd60}, 12'h0F0, 1'b1, 10, 1'b0, 1'b1, 1);
        @(negedge clk); #1;
        n_cmp++;
        if ({frame_done, busy, tri_count, fb_we, r_rst} !== {1'b0, 1'b0, NW'(1), 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL single_idle: fd=%b busy=%b count=%0d we=%b r_rst=%b, want 0 0 1 0 1",
                     frame_done, busy, tri_count, fb_we, r_rst);
        end
    endtask

    task automatic test_back_to_back();
        test_clear(12'h123, 1'b0);
        do_tri({12'd10, 12'd11, 12'd12, 12'd13, 12'd14, 12'd15}, 12'h111, 1'b0, 4, 1'b1, 1'b0, 1);
        do_tri({12'hF00, 12'hF00, 12'hF00, 12'hF00, 12'hF00, 12'hF00}, 12'h222, 1'b0, 3, 1'b1, 1'b0, 2);
        do_tri({12'd7, 12'd0, 12'd0, 12'd7, 12'd7, 12'd7}, 12'h333, 1'b1, 5, 1'b1, 1'b0, 3);
        @(negedge clk); #1;
        n_cmp++;
        if ({frame_done, busy, tri_count} !== {1'b0, 1'b0, NW'(3)}) begin
            n_err++;
            $display("FAIL b2b_idle: fd=%b busy=%b count=%0d, want 0 0 3", frame_done, busy, tri_count);
        end
    endtask

    task automatic test_reset_mid_clear();
        frame_start = 1'b1;
        clear_color = 12'h777;
        @(negedge clk); #1;
        frame_start = 1'b0;
        repeat (17) begin
            @(negedge clk); #1;
        end
        n_cmp++;
        if ({fb_we, fb_addr} !== {1'b1, AW'(17)}) begin
            n_err++;
            $display("FAIL pre_reset_addr: we=%b addr=%0d, want 1 17", fb_we, fb_addr);
        end
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({fb_we, fb_addr, fb_data, busy, r_rst, tri_ready, tri_count, frame_done} !==
            {1'b0, AW'(0), CW'(0), 1'b0, 1'b1, 1'b0, NW'(0), 1'b0}) begin
            n_err++;
            $display("FAIL mid_clear_reset: we=%b addr=%0d data=%h busy=%b r_rst=%b ready=%b count=%0d fd=%b, want reset values",
                     fb_we, fb_addr, fb_data, busy, r_rst, tri_ready, tri_count, frame_done);
        end
        n_cmp++;
        if ({r_x0, r_y0, r_x1, r_y1, r_x2, r_y2} !== '0) begin
            n_err++;
            $display("FAIL mid_clear_reset_vertices: got %h want 0", {r_x0, r_y0, r_x1, r_y1, r_x2, r_y2});
        end
        @(negedge clk); #1;
        rstn = 1'b1;
        @(negedge clk); #1;
        test_clear(12'h5A5, 1'b0);
        do_tri({12'd3, 12'd3, 12'd9, 12'd3, 12'd3, 12'd9}, 12'h444, 1'b1, 6, 1'b0, 1'b0, 1);
        @(negedge clk); #1;
    endtask

`ifdef RASTER_WATCHDOG_EN
    task automatic test_watchdog();
        test_clear(12'h000, 1'b0);
        {tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2} = {6{12'd1}};
        tri_color = 12'h0AA;
        tri_last  = 1'b0;
        tri_valid = 1'b1;
        @(posedge clk); #1;
        tri_valid = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk); #1;
            n_cmp++;
            if ({r_rst, raster_timeout, tri_count} !== {1'b0, 1'b0, NW'(0)}) begin
                n_err++;
                $display("FAIL watchdog_wait[%0d]: r_rst=%b to=%b count=%0d, want 0 0 0",
                         c, r_rst, raster_timeout, tri_count);
            end
        end
        @(negedge clk); #1;
        n_cmp++;
        if ({raster_timeout, tri_count, tri_ready, r_rst} !== {1'b1, NW'(1), 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL watchdog_fire: to=%b count=%0d ready=%b r_rst=%b, want 1 1 1 1",
                     raster_timeout, tri_count, tri_ready, r_rst);
        end
        exp_timeout = 1'b1;
        do_tri({12'd2, 12'd2, 12'd8, 12'd2, 12'd2, 12'd8}, 12'h0BB, 1'b1, 5, 1'b0, 1'b0, 2);
        @(negedge clk); #1;
    endtask
`else
    task automatic test_long_raster();
        test_clear(12'hC3C, 1'b0);
        do_tri({12'd0, 12'd0, 12'd7, 12'd0, 12'd0, 12'd3}, 12'h0CC, 1'b1, 80, 1'b0, 1'b0, 1);
        @(negedge clk); #1;
    endtask
`endif

    initial begin
        rstn        = 1'b0;
        frame_start = 1'b0;
        clear_color = '0;
        tri_valid   = 1'b0;
        tri_last    = 1'b0;
        {tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2} = '0;
        tri_color   = '0;
        r_fb_addr   = '0;
        r_fb_we     = 1'b0;
        r_done      = 1'b0;
        test_reset();
        @(negedge clk); #1;
        rstn = 1'b1;
        @(negedge clk); #1;
        test_single_triangle();
        test_back_to_back();
        test_reset_mid_clear();
`ifdef RASTER_WATCHDOG_EN
        test_watchdog();
`else
        test_long_raster();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
